obj_table_scan: RTL



---
 rtl/obj_scan_pkg.sv | 26 ++
 rtl/abs_window_cmp.sv | 23 ++
 rtl/obj_table_scan.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/obj_scan_pkg.sv
// Shared constants for the object-table scanner: FSM encodings, record layout
// and a constant-evaluable clog2.
package obj_scan_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE_X = 3'd1;
    localparam logic [2:0] ST_ISSUE_Y = 3'd2;
    localparam logic [2:0] ST_CAPT_Y  = 3'd3;
    localparam logic [2:0] ST_CMP     = 3'd4;
    localparam logic [2:0] ST_CLR_X   = 3'd5;
    localparam logic [2:0] ST_CLR_Y   = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // Record k lives at words {k, X_OFS} and {k, Y_OFS}.
    localparam logic        X_OFS         = 1'b0;
    localparam logic        Y_OFS         = 1'b1;
    localparam int unsigned WORDS_PER_REC = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/abs_window_cmp.sv
// Combinational tolerance window: in_window when |a - b| <= TOL, computed with
// one guard bit so the distance never wraps.
module abs_window_cmp #(
    parameter int unsigned DW  = 8,
    parameter int unsigned TOL = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          in_window
);

    localparam logic [DW:0] TOL_W = (DW+1)'(TOL);

    logic signed [DW:0] w_diff;
    logic        [DW:0] w_abs;

    always_comb begin
        w_diff    = $signed({1'b0, a}) - $signed({1'b0, b});
        w_abs     = w_diff[DW] ? $unsigned(-w_diff) : $unsigned(w_diff);
        in_window = (w_abs <= TOL_W);
    end

endmodule

// File: rtl/obj_table_scan.sv
// Scans (x,y) records in an external synchronous RAM against a latched query,
// reporting first/last hit and optionally zeroing hit records.
module obj_table_scan
    import obj_scan_pkg::*;
#(
    parameter  int unsigned ENTRIES = 16,
    parameter  int unsigned DW      = 8,
    parameter  int unsigned X_TOL   = 0,
    parameter  int unsigned Y_TOL   = 20,
    localparam int unsigned AW      = clog2(WORDS_PER_REC * ENTRIES),
    localparam int unsigned CW      = clog2(ENTRIES + 1),
    localparam int unsigned IW      = clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          go,
    input  logic [DW-1:0] qx,
    input  logic [DW-1:0] qy,
    input  logic          mode_all,
    input  logic          clear_en,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          busy,
    output logic          done,
    output logic          hit,
    output logic [IW-1:0] hit_idx,
    output logic [CW-1:0] hit_count,
    output logic [DW-1:0] hit_x,
    output logic [DW-1:0] hit_y
);

    logic [2:0]    r_state;
    logic [IW-1:0] r_k;
    logic [DW-1:0] r_qx, r_qy, r_rx, r_ry;
    logic          r_mode_all, r_clear_en;
    logic          r_hit;
    logic [IW-1:0] r_hit_idx;
    logic [CW-1:0] r_hit_count;
    logic [DW-1:0] r_hit_x, r_hit_y;
    logic [AW-1:0] r_addr_hold;

    logic          w_in_x, w_in_y, w_match, w_last;
    logic [AW-1:0] w_addr;
    logic          w_we;

    abs_window_cmp #(.DW(DW), .TOL(X_TOL)) u_win_x (.a(r_rx), .b(r_qx), .in_window(w_in_x));
    abs_window_cmp #(.DW(DW), .TOL(Y_TOL)) u_win_y (.a(r_ry), .b(r_qy), .in_window(w_in_y));

    // An all-zero record is an empty slot and must never match.
    assign w_match = ((r_rx != '0) || (r_ry != '0)) && w_in_x && w_in_y;
    assign w_last  = (r_k == IW'(ENTRIES - 1));

    always_comb begin
        w_addr = r_addr_hold;
        w_we   = 1'b0;
        case (r_state)
            ST_ISSUE_X: w_addr = AW'({r_k, X_OFS});
            ST_ISSUE_Y: w_addr = AW'({r_k, Y_OFS});
            ST_CLR_X: begin
                w_addr = AW'({r_k, X_OFS});
                w_we   = 1'b1;
            end
            ST_CLR_Y: begin
                w_addr = AW'({r_k, Y_OFS});
                w_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_mode_all  <= 1'b0;
            r_clear_en  <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            r_hit_count <= '0;
            r_hit_x     <= '0;
            r_hit_y     <= '0;
            r_addr_hold <= '0;
        end else begin
            r_addr_hold <= w_addr;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_qx        <= qx;
                        r_qy        <= qy;
                        r_mode_all  <= mode_all;
                        r_clear_en  <= clear_en;
                        r_k         <= '0;
                        r_hit       <= 1'b0;
                        r_hit_idx   <= '0;
                        r_hit_count <= '0;
                        r_hit_x     <= '0;
                        r_hit_y     <= '0;
                        r_state     <= ST_ISSUE_X;
                    end
                end
                ST_ISSUE_X: r_state <= ST_ISSUE_Y;
                ST_ISSUE_Y: begin
                    r_rx    <= ram_rdata;
                    r_state <= ST_CAPT_Y;
                end
                ST_CAPT_Y: begin
                    r_ry    <= ram_rdata;
                    r_state <= ST_CMP;
                end
                ST_CMP: begin
                    if (w_match) begin
                        r_hit       <= 1'b1;
                        r_hit_count <= r_hit_count + CW'(1);
                        r_hit_idx   <= r_k;
                        r_hit_x     <= r_rx;
                        r_hit_y     <= r_ry;
                    end
                    if (w_match && r_clear_en) begin
                        r_state <= ST_CLR_X;
                    end else if (w_last || (w_match && !r_mode_all)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k     <= r_k + IW'(1);
                        r_state <= ST_ISSUE_X;
                    end
                end
                ST_CLR_X: r_state <= ST_CLR_Y;
                // Only reached after a match, so the decision reduces to last/mode.
                ST_CLR_Y: begin
                    if (w_last || !r_mode_all) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k     <= r_k + IW'(1);
                        r_state <= ST_ISSUE_X;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr  = w_addr;
    assign ram_we    = w_we;
    assign ram_wdata = '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign hit       = r_hit;
    assign hit_idx   = r_hit_idx;
    assign hit_count = r_hit_count;
    assign hit_x     = r_hit_x;
    assign hit_y     = r_hit_y;

endmodule
